ram_tp_bwe_init: RTL
====================

Name: ram_tp_bwe_init

Overview:
- Two-port synchronous inferred RAM: port A read/write with per-byte write strobes, port B read-only.
- Selectable read-during-write mode on port A, optional output register stage, and a post-reset clear engine that zeroes the array before accepting traffic.
- Successor to the single-port write-first RAM. Used for cache data/tag arrays and scratchpads that need byte writes, a concurrent second reader and a known power-up state.

Parameters:
- abits, 12, address width; depth = 2**abits words.
- dbits, 64, data width; must be a multiple of 8; lanes = dbits/8.
- wrmode, 0, port A read-during-write: 0 = write-first, 1 = read-first.
- oreg, 0, 1 adds an output register stage on both ports, giving +1 cycle latency.
- init_ena, 1, 1 enables the post-reset clear engine; 0 means the array is not cleared.

Ports:
- i_clk  in  1  clock, rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- o_ready  out  1  array available; both ports ignored while 0.
- i_a_ena  in  1  port A access request.
- i_a_addr  in  abits  port A address.
- i_a_wstrb  in  dbits/8  byte write strobes; all-zero means a read.
- i_a_wdata  in  dbits  port A write data.
- o_a_rdata  out  dbits  port A read data.
- o_a_rvalid  out  1  port A data valid strobe.
- i_b_ena  in  1  port B read request.
- i_b_addr  in  abits  port B address.
- o_b_rdata  out  dbits  port B read data.
- o_b_rvalid  out  1  port B data valid strobe.

Behaviour:
- Reset (i_nrst=0, async):
  - o_a_rdata, o_b_rdata, o_a_rvalid, o_b_rvalid and all pipeline registers = 0.
  - Clear counter = 0.
  - FSM = INIT if init_ena=1, else READY.
  - o_ready = 0 if init_ena=1, else 1.
  - Array contents are not reset.
- FSM INIT:
  - Each cycle writes all-zero to address cnt; cnt increments.
  - On cnt = 2**abits-1: write it, go to READY next cycle. INIT lasts exactly 2**abits cycles.
  - o_ready is 1 from the first READY cycle.
- FSM READY: terminal state; only reset leaves it.
- Reset mid-INIT aborts the clear. On release, INIT restarts at address 0.
- Requests while o_ready=0 are dropped: no write, no rvalid. No back-pressure; upstream must wait for o_ready.
- Port A write (ena=1, wstrb!=0): only lanes with wstrb[i]=1 are updated; other lanes keep their value.
- Port A data on any access, write or read:
  - Read (wstrb=0): returns the stored word.
  - Write, wrmode=0: returns the post-write word (per-lane merge of wdata and old data).
  - Write, wrmode=1: returns the pre-write word.
- Port B: returns the stored word. If the same cycle port A writes the same address, port B returns the pre-write (old) word, regardless of wrmode.
- Latency:
  - rdata/rvalid are valid 1 cycle after the request (oreg=0) or 2 cycles after (oreg=1).
  - rvalid is a one-cycle pulse per accepted request. Back-to-back requests give back-to-back pulses at full throughput.
- Data hold: rdata holds its last value until the next accepted request on the same port. It is not cleared when rvalid=0.
- Simultaneous A and B reads to any addresses are always served in the same cycle.
- Address wrap: none. The address is used modulo depth by width.

Decomposition:
- Package ram_pkg holds:
  - constants RAM_WRITE_FIRST=0 and RAM_READ_FIRST=1;
  - the FSM state enum typedef (INIT, READY).
- Sub-module ram_lane_tp: one 8-bit, two-port, read-first lane with a write enable. Instantiated dbits/8 times via generate.
- Top-level module contains:
  - the clear FSM and counter;
  - the request mux (clear engine vs port A);
  - the write-first merge;
  - the valid and oreg pipeline.

Test Plan:
All scenarios use abits=4, dbits=32 unless stated.
1. Clear: assert reset, release, run 16 cycles.
   - o_ready rises after exactly 16 cycles.
   - Port B reads of addresses 0..15 all return 0x00000000.
2. Byte strobes: A writes 0xAABBCCDD to addr 3 with wstrb=4'hF, then 0x11223344 with wstrb=4'b0101.
   - Port B read of addr 3 returns 0xAA22CC44.
3. Read-during-write:
   - wrmode=0: addr 5 holds 0x12345678; A writes 0xFFFFFFFF with wstrb=4'b0011 → o_a_rdata = 0x1234FFFF one cycle later.
   - wrmode=1: same stimulus → o_a_rdata = 0x12345678.
4. Collision: same cycle, A writes 0xDEADBEEF to addr 7 (old value 0x0) and B reads addr 7.
   - o_b_rdata = 0x00000000; the next B read of addr 7 returns 0xDEADBEEF.
5. Latency, oreg=1: A and B reads issued in consecutive cycles to addr 1, 2, 3.
   - Rvalid pulses start 2 cycles after the first request and stay continuous for 3 cycles, with matching data.
6. Reset at INIT cycle 8, and requests before o_ready:
   - After release, INIT restarts and o_ready rises 16 cycles later.
   - An A write issued before o_ready has no effect: addr 0 still reads 0.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the two-port byte-write RAM.
//   RAM_WRITE_FIRST / RAM_READ_FIRST : values for the wrmode parameter.
//   ram_state_e                      : clear-engine FSM state.
package ram_pkg;

    localparam int RAM_WRITE_FIRST = 0;
    localparam int RAM_READ_FIRST  = 1;

    typedef enum logic {
        RAM_INIT  = 1'b0,
        RAM_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_lane_tp.sv
// ram_lane_tp: one 8-bit lane of the two-port RAM.
//   Port A: write (i_we) and read at i_a_addr. The read is read-first, so it
//           returns the word as it was before a same-cycle write.
//   Port B: read-only at i_b_addr. It also sees the pre-write word.
//   Each read register loads only when its read enable is high and holds
//   otherwise. Both read registers clear on reset; the array does not.
// Ports:
//   i_clk, i_nrst             clock, async active-low reset
//   i_we                      lane write enable (port A address)
//   i_a_re, i_a_addr          port A read enable / address
//   i_a_wdata, o_a_rdata      port A write byte / read byte
//   i_b_re, i_b_addr          port B read enable / address
//   o_b_rdata                 port B read byte
module ram_lane_tp #(
    parameter int abits = 12
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_we,
    input  logic             i_a_re,
    input  logic [abits-1:0] i_a_addr,
    input  logic [7:0]       i_a_wdata,
    output logic [7:0]       o_a_rdata,
    input  logic             i_b_re,
    input  logic [abits-1:0] i_b_addr,
    output logic [7:0]       o_b_rdata
);

    logic [7:0] mem_q [0:(1<<abits)-1];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_a_addr] <= i_a_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (i_a_re) a_rdata_q <= mem_q[i_a_addr];
            if (i_b_re) b_rdata_q <= mem_q[i_b_addr];
        end
    end

    assign o_a_rdata = a_rdata_q;
    assign o_b_rdata = b_rdata_q;

endmodule

// File: rtl/ram_tp_bwe_init.sv
// ram_tp_bwe_init: two-port RAM, port A read/write with byte strobes, port B
// read-only, with a post-reset clear engine and optional output register.
//   o_ready   : array available; requests are dropped while low.
//   Port A    : i_a_ena/i_a_addr/i_a_wstrb/i_a_wdata -> o_a_rdata/o_a_rvalid
//               wstrb == 0 is a read; otherwise only strobed lanes update.
//               wrmode 0 returns the merged new word, 1 the old word.
//   Port B    : i_b_ena/i_b_addr -> o_b_rdata/o_b_rvalid, always old word.
//   o_state   : clear-engine FSM state, for observation only.
// Latency is 1 cycle (oreg=0) or 2 cycles (oreg=1); rdata holds between
// accepted requests.
module ram_tp_bwe_init
    import ram_pkg::*;
#(
    parameter int abits    = 12,
    parameter int dbits    = 64,
    parameter int wrmode   = RAM_WRITE_FIRST,
    parameter int oreg     = 0,
    parameter int init_ena = 1
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    output logic               o_ready,
    input  logic               i_a_ena,
    input  logic [abits-1:0]   i_a_addr,
    input  logic [dbits/8-1:0] i_a_wstrb,
    input  logic [dbits-1:0]   i_a_wdata,
    output logic [dbits-1:0]   o_a_rdata,
    output logic               o_a_rvalid,
    input  logic               i_b_ena,
    input  logic [abits-1:0]   i_b_addr,
    output logic [dbits-1:0]   o_b_rdata,
    output logic               o_b_rvalid,
    output ram_state_e         o_state
);

    localparam int LANES = dbits / 8;

    // ---------------- clear engine ----------------
    ram_state_e       state_q, state_d;
    logic [abits-1:0] cnt_q, cnt_d;
    logic             ready;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= (init_ena != 0) ? RAM_INIT : RAM_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RAM_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {abits{1'b1}}) begin
                state_d = RAM_READY;
            end
        end
    end

    assign ready   = (state_q == RAM_READY);
    assign o_ready = ready;
    assign o_state = state_q;

    // ---------------- request mux ----------------
    logic             a_acc, b_acc;
    logic [abits-1:0] wr_addr;
    logic [dbits-1:0] wr_data;
    logic [LANES-1:0] wr_en;

    assign a_acc = ready & i_a_ena;
    assign b_acc = ready & i_b_ena;

    // The clear engine owns the port A address/write path until ready.
    always_comb begin
        wr_addr = i_a_addr;
        wr_data = i_a_wdata;
        wr_en   = {LANES{a_acc}} & i_a_wstrb;
        if (!ready) begin
            wr_addr = cnt_q;
            wr_data = '0;
            wr_en   = {LANES{1'b1}};
        end
    end

    // ---------------- lanes ----------------
    logic [dbits-1:0] lane_a, lane_b;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ram_lane_tp #(.abits(abits)) u_lane (
            .i_clk     (i_clk),
            .i_nrst    (i_nrst),
            .i_we      (wr_en[g]),
            .i_a_re    (a_acc),
            .i_a_addr  (wr_addr),
            .i_a_wdata (wr_data[8*g +: 8]),
            .o_a_rdata (lane_a[8*g +: 8]),
            .i_b_re    (b_acc),
            .i_b_addr  (i_b_addr),
            .o_b_rdata (lane_b[8*g +: 8])
        );
    end

    // ---------------- stage 1: valid + write-first merge ----------------
    logic             a_v1_q, b_v1_q;
    logic [LANES-1:0] a_wsel_q;
    logic [dbits-1:0] a_wdata_q;
    logic [dbits-1:0] a_data1;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            a_v1_q    <= 1'b0;
            b_v1_q    <= 1'b0;
            a_wsel_q  <= '0;
            a_wdata_q <= '0;
        end else begin
            a_v1_q <= a_acc;
            b_v1_q <= b_acc;
            // Loaded only on accepted requests so the merged word holds.
            if (a_acc) begin
                a_wsel_q  <= i_a_wstrb;
                a_wdata_q <= i_a_wdata;
            end
        end
    end

    // Lanes are read-first; write-first substitutes the written bytes.
    always_comb begin
        a_data1 = lane_a;
        if (wrmode == RAM_WRITE_FIRST) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_wsel_q[i]) a_data1[8*i +: 8] = a_wdata_q[8*i +: 8];
            end
        end
    end

    // ---------------- optional output register ----------------
    if (oreg != 0) begin : g_oreg
        logic             a_v2_q, b_v2_q;
        logic [dbits-1:0] a_d2_q, b_d2_q;

        always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
                a_v2_q <= 1'b0;
                b_v2_q <= 1'b0;
                a_d2_q <= '0;
                b_d2_q <= '0;
            end else begin
                a_v2_q <= a_v1_q;
                b_v2_q <= b_v1_q;
                if (a_v1_q) a_d2_q <= a_data1;
                if (b_v1_q) b_d2_q <= lane_b;
            end
        end

        assign o_a_rdata  = a_d2_q;
        assign o_a_rvalid = a_v2_q;
        assign o_b_rdata  = b_d2_q;
        assign o_b_rvalid = b_v2_q;
    end else begin : g_noreg
        assign o_a_rdata  = a_data1;
        assign o_a_rvalid = a_v1_q;
        assign o_b_rdata  = lane_b;
        assign o_b_rvalid = b_v1_q;
    end

endmodule
